// File: rtl/ams_pwm_dither_gen.sv
// 8-bit PWM generator with a 16-period dither pattern that gives 12-bit average resolution.
// The dither feature is compiled in only when the macro AMS_PWM_DITHER_EN is defined.
module ams_pwm_dither_gen #(
    parameter int               CCW      = 24,
    parameter logic [CCW-1:0]   INIT_CFG = 24'h000000
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [CCW-1:0]   cfg_i,
    input  logic             en_i,
    output logic             pwm_o,
    output logic             frame_o,
    output logic [CCW-1:0]   cfg_r_o
);

    logic [7:0] cnt_reg, cnt_next;
    logic [3:0] seq_reg, seq_next;
    logic [7:0] duty_reg, duty_next;
    logic       pwm_reg, pwm_next;
    logic       frame_reg, frame_next;
    logic       load;
    logic       dith_bit;
    logic [8:0] thr;

`ifdef AMS_PWM_DITHER_EN
    logic [15:0] dith_reg, dith_next;

    always_comb begin
        dith_next = dith_reg;
        if (!en_i || load) begin
            dith_next = cfg_i[15:0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dith_reg <= INIT_CFG[15:0];
        end else begin
            dith_reg <= dith_next;
        end
    end

    assign dith_bit = dith_reg[seq_reg];
    assign cfg_r_o  = {duty_reg, dith_reg};
`else
    // Pattern bits are not stored in this build; keep them visibly unused.
    logic unused_dith;
    assign unused_dith = ^cfg_i[15:0];
    assign dith_bit    = 1'b0;
    assign cfg_r_o     = {duty_reg, 16'h0000};
`endif

    // Shadow reload happens only on the last clock of a frame.
    assign load = en_i && (cnt_reg == 8'hFF) && (seq_reg == 4'hF);
    assign thr  = {1'b0, duty_reg} + {8'd0, dith_bit};

    always_comb begin
        cnt_next   = 8'd0;
        seq_next   = 4'd0;
        pwm_next   = 1'b0;
        frame_next = 1'b0;
        duty_next  = cfg_i[23:16];
        if (en_i) begin
            cnt_next   = cnt_reg + 8'd1;
            seq_next   = (cnt_reg == 8'hFF) ? seq_reg + 4'd1 : seq_reg;
            pwm_next   = ({1'b0, cnt_reg} < thr);
            frame_next = (cnt_reg == 8'd0) && (seq_reg == 4'd0);
            duty_next  = load ? cfg_i[23:16] : duty_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_reg   <= 8'd0;
            seq_reg   <= 4'd0;
            duty_reg  <= INIT_CFG[23:16];
            pwm_reg   <= 1'b0;
            frame_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            seq_reg   <= seq_next;
            duty_reg  <= duty_next;
            pwm_reg   <= pwm_next;
            frame_reg <= frame_next;
        end
    end

    assign pwm_o   = pwm_reg;
    assign frame_o = frame_reg;

endmodule

// File: tb/tb_ams_pwm_dither_gen.sv
// Self-checking bench for ams_pwm_dither_gen; expectations follow the build's AMS_PWM_DITHER_EN setting.
module tb_ams_pwm_dither_gen;

    localparam logic [23:0] INIT = 24'h5A3C96;
`ifdef AMS_PWM_DITHER_EN
    localparam bit          DITH = 1'b1;
`else
    localparam bit          DITH = 1'b0;
`endif
    localparam logic [23:0] MASK = DITH ? 24'hFFFFFF : 24'hFF0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] cfg = 24'h0;
    logic        en = 1'b0;
    logic        pwm;
    logic        frame;
    logic [23:0] cfg_r;

    int checks = 0;
    int passed = 0;

    ams_pwm_dither_gen #(.CCW(24), .INIT_CFG(INIT)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .cfg_i   (cfg),
        .en_i    (en),
        .pwm_o   (pwm),
        .frame_o (frame),
        .cfg_r_o (cfg_r)
    );

    always #5 clk = ~clk;

    // High clocks in period p of a frame running configuration c.
    function automatic int period_high(input logic [23:0] c, input int p);
        return int'(c[23:16]) + (DITH ? int'(c[p]) : 0);
    endfunction

    // Reference model: position within the 4096-clock frame plus the active config.
    int          m_pos;
    logic [23:0] m_cfg;
    logic        exp_pwm;
    logic        exp_frame;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pos     <= 0;
            m_cfg     <= INIT & MASK;
            exp_pwm   <= 1'b0;
            exp_frame <= 1'b0;
        end else if (!en) begin
            m_pos     <= 0;
            m_cfg     <= cfg & MASK;
            exp_pwm   <= 1'b0;
            exp_frame <= 1'b0;
        end else begin
            exp_pwm   <= ((m_pos % 256) < period_high(m_cfg, m_pos / 256));
            exp_frame <= (m_pos == 0);
            if (m_pos == 4095) m_cfg <= cfg & MASK;
            m_pos     <= (m_pos + 1) % 4096;
        end
    end

    int hi [16];
    int tot;
    int mism;
    int nfr;
    logic first_fr;

    // Load c while disabled, enable, and record one full frame of output.
    task automatic run_frame(input logic [23:0] c);
        @(negedge clk);
        en  = 1'b0;
        cfg = c;
        @(negedge clk);
        en = 1'b1;
        tot = 0; mism = 0; nfr = 0; first_fr = 1'b0;
        for (int p = 0; p < 16; p++) hi[p] = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            if (pwm === 1'b1) begin
                hi[k / 256]++;
                tot++;
            end
            if (frame === 1'b1) nfr++;
            if (k == 0) first_fr = frame;
            if (pwm !== exp_pwm || frame !== exp_frame || cfg_r !== m_cfg) mism++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cfg  = 24'hFFFFFF;
        en   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm !== 1'b0) $display("FAIL reset_pwm: got %b want 0", pwm); else passed++;
        checks++;
        if (frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame); else passed++;
        checks++;
        if (cfg_r !== (INIT & MASK)) $display("FAIL reset_cfg_r: got %h want %h", cfg_r, INIT & MASK);
        else passed++;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (frame !== 1'b1) $display("FAIL reset_first_frame: got %b want 1", frame); else passed++;
        checks++;
        if (pwm !== (period_high(INIT & MASK, 0) > 0)) $display("FAIL reset_first_pwm: got %b", pwm);
        else passed++;
        @(negedge clk);
        checks++;
        if (frame !== 1'b0) $display("FAIL reset_frame_width: got %b want 0", frame); else passed++;
        $display("reset: pwm=%b frame=%b cfg_r=%h", pwm, frame, cfg_r);
    endtask

    task automatic test_base_duty();
        int bad = 0;
        run_frame(24'h800000);
        for (int p = 0; p < 16; p++) if (hi[p] != 128) bad++;
        checks++;
        if (tot != 2048) $display("FAIL base_total: got %0d want 2048", tot); else passed++;
        checks++;
        if (bad != 0) $display("FAIL base_periods: %0d periods not 128 high", bad); else passed++;
        checks++;
        if (first_fr !== 1'b1 || nfr != 1) $display("FAIL base_frame: first=%b pulses=%0d want 1/1", first_fr, nfr);
        else passed++;
        checks++;
        if (mism != 0) $display("FAIL base_model: %0d cycles differ from model", mism); else passed++;
        $display("base duty 800000: high=%0d", tot);
    endtask

    task automatic test_dither_pattern();
        int bad = 0;
        run_frame(24'h400001);
        checks++;
        if (hi[0] != (DITH ? 65 : 64)) $display("FAIL dith1_period0: got %0d want %0d", hi[0], DITH ? 65 : 64);
        else passed++;
        checks++;
        if (tot != (DITH ? 1025 : 1024)) $display("FAIL dith1_total: got %0d want %0d", tot, DITH ? 1025 : 1024);
        else passed++;
        checks++;
        if (mism != 0) $display("FAIL dith1_model: %0d cycles differ", mism); else passed++;
        $display("dither 400001: p0=%0d p1=%0d high=%0d", hi[0], hi[1], tot);
        run_frame(24'h40FFFF);
        for (int p = 0; p < 16; p++) if (hi[p] != (DITH ? 65 : 64)) bad++;
        checks++;
        if (bad != 0) $display("FAIL dithF_periods: %0d periods wrong", bad); else passed++;
        checks++;
        if (tot != (DITH ? 1040 : 1024)) $display("FAIL dithF_total: got %0d want %0d", tot, DITH ? 1040 : 1024);
        else passed++;
        checks++;
        if (cfg_r !== (DITH ? 24'h40FFFF : 24'h400000)) $display("FAIL dithF_cfg_r: got %h", cfg_r);
        else passed++;
        $display("dither 40FFFF: high=%0d cfg_r=%h", tot, cfg_r);
    endtask

    task automatic test_boundaries();
        int bad = 0;
        run_frame(24'h000000);
        checks++;
        if (tot != 0 || mism != 0) $display("FAIL bnd_zero: high=%0d mism=%0d want 0/0", tot, mism); else passed++;
        $display("boundary 000000: high=%0d", tot);
        run_frame(24'hFFFFFF);
        checks++;
        if (tot != (DITH ? 4096 : 4080)) $display("FAIL bnd_full: got %0d want %0d", tot, DITH ? 4096 : 4080);
        else passed++;
        checks++;
        if (hi[15] != (DITH ? 256 : 255) || mism != 0) $display("FAIL bnd_full_p15: got %0d mism=%0d", hi[15], mism);
        else passed++;
        $display("boundary FFFFFF: high=%0d", tot);
        run_frame(24'hFF0000);
        for (int p = 0; p < 16; p++) if (hi[p] != 255) bad++;
        checks++;
        if (bad != 0 || tot != 4080) $display("FAIL bnd_ff: bad=%0d high=%0d want 0/4080", bad, tot); else passed++;
        checks++;
        if (mism != 0) $display("FAIL bnd_ff_model: %0d cycles differ", mism); else passed++;
        $display("boundary FF0000: high=%0d", tot);
    endtask

    task automatic test_shadow_timing();
        int h0 [16];
        int h1 [16];
        int bad0 = 0;
        int bad1 = 0;
        int sm = 0;
        logic [23:0] before_load = 24'h0;
        logic [23:0] after_load = 24'h0;
        logic        fr_next = 1'b0;
        @(negedge clk);
        en  = 1'b0;
        cfg = 24'h100000;
        @(negedge clk);
        en = 1'b1;
        for (int p = 0; p < 16; p++) begin h0[p] = 0; h1[p] = 0; end
        for (int k = 0; k < 8192; k++) begin
            @(negedge clk);
            if (pwm === 1'b1) begin
                if (k < 4096) h0[k / 256]++; else h1[(k - 4096) / 256]++;
            end
            if (pwm !== exp_pwm || frame !== exp_frame || cfg_r !== m_cfg) sm++;
            if (k == 4094) before_load = cfg_r;
            if (k == 4095) after_load = cfg_r;
            if (k == 4096) fr_next = frame;
            if (k == 777) cfg = 24'hF00000;
        end
        for (int p = 0; p < 16; p++) begin
            if (h0[p] != 16) bad0++;
            if (h1[p] != 240) bad1++;
        end
        checks++;
        if (bad0 != 0) $display("FAIL shadow_old: %0d periods not 16 high", bad0); else passed++;
        checks++;
        if (bad1 != 0) $display("FAIL shadow_new: %0d periods not 240 high", bad1); else passed++;
        checks++;
        if (before_load !== 24'h100000) $display("FAIL shadow_cfg_pre: got %h want 100000", before_load);
        else passed++;
        checks++;
        if (after_load !== 24'hF00000) $display("FAIL shadow_cfg_post: got %h want f00000", after_load);
        else passed++;
        checks++;
        if (fr_next !== 1'b1) $display("FAIL shadow_frame: got %b want 1", fr_next); else passed++;
        checks++;
        if (sm != 0) $display("FAIL shadow_model: %0d cycles differ", sm); else passed++;
        $display("shadow: old p3=%0d new p0=%0d cfg_r %h->%h", h0[3], h1[0], before_load, after_load);
    endtask

    task automatic test_disable();
        int stuck = 0;
        logic pre_pwm;
        run_frame(24'hFFFFFF);
        for (int k = 0; k < 900; k++) @(negedge clk);
        pre_pwm = pwm;
        checks++;
        if (pre_pwm !== 1'b1) $display("FAIL dis_pre_pwm: got %b want 1", pre_pwm); else passed++;
        en  = 1'b0;
        cfg = 24'h20ABCD;
        @(negedge clk);
        checks++;
        if (pwm !== 1'b0 || frame !== 1'b0) $display("FAIL dis_pwm: pwm=%b frame=%b want 0/0", pwm, frame);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (pwm !== 1'b0 || frame !== 1'b0) stuck++;
        end
        checks++;
        if (stuck != 0) $display("FAIL dis_hold: %0d cycles active while disabled", stuck); else passed++;
        checks++;
        if (cfg_r !== (24'h20ABCD & MASK)) $display("FAIL dis_cfg_live: got %h want %h", cfg_r, 24'h20ABCD & MASK);
        else passed++;
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (frame !== 1'b1 || pwm !== 1'b1) $display("FAIL dis_reenable: frame=%b pwm=%b want 1/1", frame, pwm);
        else passed++;
        $display("disable/re-enable: frame=%b cfg_r=%h", frame, cfg_r);
    endtask

    task automatic test_random();
        int rm = 0;
        int off = 0;
        cfg = $urandom();
        for (int k = 0; k < 14000; k++) begin
            @(negedge clk);
            if (pwm !== exp_pwm || frame !== exp_frame || cfg_r !== m_cfg) rm++;
            if (k == 7000) begin
                #2 rstn = 1'b0;
                #1;
                checks++;
                if (pwm !== 1'b0 || frame !== 1'b0 || cfg_r !== (INIT & MASK))
                    $display("FAIL rand_async_reset: pwm=%b frame=%b cfg_r=%h", pwm, frame, cfg_r);
                else passed++;
            end else if (k == 7001) begin
                rstn = 1'b1;
            end
            if ($urandom_range(99) == 0) cfg = $urandom();
            if (off > 0) begin
                off--;
                if (off == 0) en = 1'b1;
            end else if ($urandom_range(3999) == 0) begin
                en  = 1'b0;
                off = $urandom_range(5, 1);
            end
        end
        en = 1'b1;
        checks++;
        if (rm != 0) $display("FAIL rand_model: %0d cycles differ from model", rm); else passed++;
        $display("random: 14000 cycles, %0d model differences", rm);
    endtask

    initial begin
        test_reset();
        test_base_duty();
        test_dither_pattern();
        test_boundaries();
        test_shadow_timing();
        test_disable();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
